// File: rtl/resonator_dds_phase_acc.sv
// Time-multiplexed per-channel phase accumulator for the resonator DDS.
// Emits the sine LUT address and the unsigned interpolation residual of each channel's phase.
module resonator_dds_phase_acc #(
    parameter int N_CHAN  = 256,
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 10,
    parameter int FRAC_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      run,
    input  logic                      cfg_we,
    input  logic [$clog2(N_CHAN)-1:0] cfg_chan,
    input  logic [PHASE_W-1:0]        cfg_inc,
    input  logic                      cfg_commit,
    input  logic                      cfg_phase_clr,
    output logic                      cfg_busy,
    output logic                      out_valid,
    output logic [$clog2(N_CHAN)-1:0] out_chan,
    output logic                      out_first,
    output logic [ADDR_W-1:0]         out_addr,
    output logic [FRAC_W-1:0]         out_frac
);

    localparam int CHAN_W = $clog2(N_CHAN);
    localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(N_CHAN - 1);

    logic [PHASE_W-1:0] phase_mem [N_CHAN];
    logic [PHASE_W-1:0] bank0_mem [N_CHAN];
    logic [PHASE_W-1:0] bank1_mem [N_CHAN];

    logic [CHAN_W-1:0] chan_cnt;
    logic              sel;
    logic              commit_pend;
    logic              clr_pend;
    logic              clr_frame;
    logic              inc_ok;

    logic              s1_valid;
    logic [CHAN_W-1:0] s1_chan;
    logic [ADDR_W-1:0] s1_addr;
    logic [FRAC_W-1:0] s1_frac;

    logic               advance;
    logic               boundary;
    logic               cfg_wr_ok;
    logic [PHASE_W-1:0] old_phase;
    logic [PHASE_W-1:0] cur_inc;
    logic [PHASE_W-1:0] new_phase;

    assign advance   = ce & run;
    assign boundary  = advance && (chan_cnt == LAST_CHAN);
    assign cfg_wr_ok = cfg_we & ~commit_pend;
    assign cfg_busy  = commit_pend;

    // Read and write-back of a channel happen in the same cycle, so even two channels never see a stale phase.
    assign old_phase = clr_frame ? '0 : phase_mem[chan_cnt];
    assign cur_inc   = !inc_ok ? '0 : (sel ? bank1_mem[chan_cnt] : bank0_mem[chan_cnt]);
    assign new_phase = old_phase + cur_inc;

    always_ff @(posedge clk) begin
        if (advance) begin
            phase_mem[chan_cnt] <= new_phase;
        end
        if (cfg_wr_ok && sel) begin
            bank0_mem[cfg_chan] <= cfg_inc;
        end
        if (cfg_wr_ok && !sel) begin
            bank1_mem[cfg_chan] <= cfg_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chan_cnt    <= '0;
            sel         <= 1'b0;
            commit_pend <= 1'b0;
            clr_pend    <= 1'b0;
            clr_frame   <= 1'b1;
            inc_ok      <= 1'b0;
            s1_valid    <= 1'b0;
            s1_chan     <= '0;
            s1_addr     <= '0;
            s1_frac     <= '0;
            out_valid   <= 1'b0;
            out_chan    <= '0;
            out_first   <= 1'b0;
            out_addr    <= '0;
            out_frac    <= '0;
        end else begin
            if (cfg_commit && !commit_pend) begin
                commit_pend <= 1'b1;
            end
            if (cfg_phase_clr) begin
                clr_pend <= 1'b1;
            end
            if (advance) begin
                chan_cnt <= chan_cnt + 1'b1;
            end
            // A clear requested on the boundary cycle itself is carried into the next frame's pending flag.
            if (boundary) begin
                if (commit_pend) begin
                    sel         <= ~sel;
                    inc_ok      <= 1'b1;
                    commit_pend <= 1'b0;
                end
                clr_frame <= clr_pend;
                clr_pend  <= cfg_phase_clr;
            end
            if (ce) begin
                s1_valid  <= advance;
                s1_chan   <= chan_cnt;
                s1_addr   <= old_phase[PHASE_W-1 -: ADDR_W];
                s1_frac   <= old_phase[PHASE_W-ADDR_W-1 -: FRAC_W];
                out_valid <= s1_valid;
                out_chan  <= s1_chan;
                out_first <= s1_valid && (s1_chan == '0);
                out_addr  <= s1_addr;
                out_frac  <= s1_frac;
            end
        end
    end

endmodule

// File: tb/tb_resonator_dds_phase_acc.sv
// Bench for resonator_dds_phase_acc with four channels: directed table, corner sequences
// and randomized traffic scored against a transaction-level reference model.
module tb_resonator_dds_phase_acc;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        run = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_chan = '0;
    logic [31:0] cfg_inc = '0;
    logic        cfg_commit = 1'b0;
    logic        cfg_phase_clr = 1'b0;
    logic        cfg_busy;
    logic        out_valid;
    logic [1:0]  out_chan;
    logic        out_first;
    logic [9:0]  out_addr;
    logic [15:0] out_frac;

    resonator_dds_phase_acc #(
        .N_CHAN(N), .PHASE_W(32), .ADDR_W(10), .FRAC_W(16)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .run(run),
        .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_inc(cfg_inc),
        .cfg_commit(cfg_commit), .cfg_phase_clr(cfg_phase_clr),
        .cfg_busy(cfg_busy), .out_valid(out_valid), .out_chan(out_chan),
        .out_first(out_first), .out_addr(out_addr), .out_frac(out_frac)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: per-channel phases, two increment tables, and a FIFO of emitted phases.
    typedef struct { int chan; logic [31:0] ph; } exp_t;
    logic [31:0] m_phase [N];
    logic [31:0] m_bank [2][N];
    int          m_cnt;
    int          m_act;
    bit          m_en, m_pend, m_pclr, m_clr_now, m_valid;
    exp_t        sbq[$];
    bit          vq[$];
    bit          h_valid;
    int          h_chan;
    logic [31:0] h_ph;

    typedef struct {
        bit ce, run, we; int wch; logic [31:0] winc; bit cm;
        bit ev; int ech; int ea; bit eb;
    } vec_t;
    vec_t tbl [21];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_act = 0; m_en = 0; m_pend = 0; m_pclr = 0; m_clr_now = 1;
        m_valid = 0; h_valid = 0; h_chan = 0; h_ph = '0;
        sbq.delete();
        vq.delete();
        vq.push_back(1'b0);
    endtask

    task automatic model_step(input bit c, input bit r, input bit we, input int wc,
                              input logic [31:0] wi, input bit cm, input bit cl);
        int ch;
        logic [31:0] old;
        logic [31:0] inc;
        if (we && !m_pend) m_bank[1-m_act][wc] = wi;
        if (c && r) begin
            ch  = m_cnt;
            old = m_clr_now ? 32'd0 : m_phase[ch];
            inc = m_en ? m_bank[m_act][ch] : 32'd0;
            m_phase[ch] = old + inc;
            sbq.push_back('{ch, old});
            m_cnt = (m_cnt + 1) % N;
            if (ch == N - 1) begin
                if (m_pend) begin
                    m_act = 1 - m_act; m_en = 1; m_pend = 0;
                end else if (cm) begin
                    m_pend = 1;
                end
                m_clr_now = m_pclr;
                m_pclr = cl;
            end else begin
                if (cm) m_pend = 1;
                if (cl) m_pclr = 1;
            end
        end else begin
            if (cm) m_pend = 1;
            if (cl) m_pclr = 1;
        end
        if (c) begin
            vq.push_back(c && r);
            m_valid = vq.pop_front();
        end
    endtask

    task automatic check_outputs(input bit c);
        exp_t e;
        chk("busy", cfg_busy, m_pend);
        if (c) begin
            chk("valid", out_valid, m_valid);
            h_valid = m_valid;
            if (m_valid && sbq.size() > 0) begin
                e = sbq.pop_front();
                h_chan = e.chan;
                h_ph = e.ph;
                chk("chan", out_chan, e.chan);
                chk("first", out_first, e.chan == 0);
                chk("addr", out_addr, e.ph >> 22);
                chk("frac", out_frac, (e.ph >> 6) & 32'hFFFF);
            end
        end else begin
            chk("hold_valid", out_valid, h_valid);
            if (h_valid) begin
                chk("hold_chan", out_chan, h_chan);
                chk("hold_addr", out_addr, h_ph >> 22);
                chk("hold_frac", out_frac, (h_ph >> 6) & 32'hFFFF);
            end
        end
    endtask

    task automatic drive(input bit c, input bit r, input bit we, input int wc,
                         input logic [31:0] wi, input bit cm, input bit cl);
        ce = c; run = r; cfg_we = we; cfg_chan = wc[1:0]; cfg_inc = wi;
        cfg_commit = cm; cfg_phase_clr = cl;
        model_step(c, r, we, wc, wi, cm, cl);
        @(posedge clk);
        #1;
        cfg_we = 1'b0; cfg_commit = 1'b0; cfg_phase_clr = 1'b0;
        check_outputs(c);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic run_until_cnt(input int k);
        for (int i = 0; i < N && m_cnt != k; i++) drive(1, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        reset = 1'b1; ce = 1'b0; run = 1'b0;
        cfg_we = 1'b0; cfg_commit = 1'b0; cfg_phase_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_chan", out_chan, 0);
        chk("rst_first", out_first, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_frac", out_frac, 0);
        reset = 1'b0;
    endtask

    initial begin
        //          ce run we wch winc          cm  ev ech ea eb
        tbl[0]  = '{1, 1, 1, 0, 32'h0000_0000, 0,  0, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 1, 32'h0040_0000, 0,  1, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 2, 32'h0000_0000, 0,  1, 1, 0, 0};
        tbl[3]  = '{1, 1, 1, 3, 32'h0000_0000, 1,  1, 2, 0, 1};
        tbl[4]  = '{1, 1, 0, 0, 32'h0,         0,  1, 3, 0, 1};
        tbl[5]  = '{1, 1, 0, 0, 32'h0,         0,  1, 0, 0, 1};
        tbl[6]  = '{1, 1, 0, 0, 32'h0,         0,  1, 1, 0, 1};
        tbl[7]  = '{1, 1, 0, 0, 32'h0,         0,  1, 2, 0, 0};
        tbl[8]  = '{1, 1, 0, 0, 32'h0,         0,  1, 3, 0, 0};
        tbl[9]  = '{1, 1, 0, 0, 32'h0,         0,  1, 0, 0, 0};
        tbl[10] = '{1, 1, 0, 0, 32'h0,         0,  1, 1, 0, 0};
        tbl[11] = '{1, 1, 0, 0, 32'h0,         0,  1, 2, 0, 0};
        tbl[12] = '{1, 1, 0, 0, 32'h0,         0,  1, 3, 0, 0};
        tbl[13] = '{1, 1, 0, 0, 32'h0,         0,  1, 0, 0, 0};
        tbl[14] = '{0, 1, 0, 0, 32'h0,         0,  1, 0, 0, 0};
        tbl[15] = '{1, 0, 0, 0, 32'h0,         0,  1, 1, 1, 0};
        tbl[16] = '{1, 1, 0, 0, 32'h0,         0,  0, 0, 0, 0};
        tbl[17] = '{1, 1, 0, 0, 32'h0,         0,  1, 2, 0, 0};
        tbl[18] = '{1, 1, 0, 0, 32'h0,         0,  1, 3, 0, 0};
        tbl[19] = '{1, 1, 0, 0, 32'h0,         0,  1, 0, 0, 0};
        tbl[20] = '{1, 1, 0, 0, 32'h0,         0,  1, 1, 2, 0};

        apply_reset();

        // Directed table: zero phases, commit on a boundary, freeze and bubble.
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].ce, tbl[i].run, tbl[i].we, tbl[i].wch, tbl[i].winc, tbl[i].cm, 0);
            chk("tbl_valid", out_valid, tbl[i].ev);
            chk("tbl_busy", cfg_busy, tbl[i].eb);
            if (tbl[i].ev) begin
                chk("tbl_chan", out_chan, tbl[i].ech);
                chk("tbl_first", out_first, tbl[i].ech == 0);
                chk("tbl_addr", out_addr, tbl[i].ea);
                chk("tbl_frac", out_frac, 0);
            end
        end

        // Fill the other bank with fine, coarse and wrapping increments; commit mid-frame.
        drive(1, 0, 1, 0, 32'h0010_0000, 0, 0);
        drive(1, 0, 1, 1, 32'hFFC0_0000, 0, 0);
        drive(1, 0, 1, 2, 32'h0000_0040, 0, 0);
        drive(1, 0, 1, 3, 32'h0100_0000, 0, 0);
        run_until_cnt(1);
        drive(1, 1, 0, 0, 0, 1, 0);
        chk("busy_after_commit", cfg_busy, 1);
        drive(1, 1, 1, 3, 32'h1234_5678, 0, 0);
        run_cycles(20);

        // Phase clear mid-frame, repeated pulse, then a clear on a boundary cycle.
        run_until_cnt(2);
        drive(1, 1, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 1);
        run_cycles(12);
        run_until_cnt(3);
        drive(1, 1, 0, 0, 0, 0, 1);
        run_cycles(12);

        // Reset mid-frame with a commit pending.
        run_until_cnt(2);
        drive(1, 1, 0, 0, 0, 1, 0);
        reset = 1'b1;
        #2;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", cfg_busy, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_cycles(8);
        drive(1, 1, 1, 0, 32'h0000_1000, 0, 0);
        drive(1, 1, 1, 1, 32'h0200_0000, 0, 0);
        drive(1, 1, 1, 2, 32'h8000_0000, 0, 0);
        drive(1, 1, 1, 3, 32'h0000_0041, 1, 0);
        run_cycles(16);

        // Randomized traffic: clock-enable gaps, bubbles, writes, commits and clears.
        for (int i = 0; i < 1200; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
                  $urandom_range(0, 3) == 0, int'($urandom_range(0, N - 1)), $urandom,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 49) == 0);
        end
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/resonator_dds_phase_acc.md
Name: resonator_dds_phase_acc

Overview:
- Time-multiplexed per-channel phase accumulator; the stage directly upstream of the resonator DDS interpolation multiplier.
- Each cycle it advances one channel's phase by that channel's tuning increment.
- It emits a LUT address (to the sine table) and an unsigned fractional residual. The residual is the 16-bit unsigned din0 operand of the interpolation multiplier.
- Increments are double-buffered and swap only at frame boundaries, so retuning never tears a frame.

Parameters:
- N_CHAN, 256, channels per frame (power of 2, >=2)
- PHASE_W, 32, accumulator width; wraps mod 2^PHASE_W
- ADDR_W, 10, LUT address width = phase[PHASE_W-1 -: ADDR_W]
- FRAC_W, 16, residual width = next FRAC_W bits below address; remaining LSBs discarded (truncate). Requires ADDR_W+FRAC_W <= PHASE_W.

Ports:
- clk, in, 1, clock
- reset, in, 1, asynchronous active-high reset
- ce, in, 1, clock enable; low freezes all datapath/pipeline state
- run, in, 1, advance channel counter when ce&run
- cfg_we, in, 1, write cfg_inc into shadow bank
- cfg_chan, in, log2(N_CHAN), write address
- cfg_inc, in, PHASE_W, unsigned increment
- cfg_commit, in, 1, pulse: request bank swap at next frame boundary
- cfg_phase_clr, in, 1, pulse: zero all phases at next frame boundary
- cfg_busy, out, 1, commit pending
- out_valid, out, 1, output qualifier
- out_chan, out, log2(N_CHAN), channel index of output
- out_first, out, 1, out_chan==0
- out_addr, out, ADDR_W, sine LUT address
- out_frac, out, FRAC_W, unsigned residual (multiplier din0)

Behaviour:
- Reset: chan counter=0, bank sel=0, commit_pend=0, clr_pend=0, clr_frame=1, inc_ok=0, cfg_busy=0. Outputs: out_valid=0, out_chan=0, out_first=0, out_addr=0, out_frac=0. RAM contents are not reset.
- Advance cycle (ce&run): channel c=counter is processed.
  - old = clr_frame ? 0 : phase[c]; inc = inc_ok ? bankA[c] : 0 (bankA = active bank).
  - phase[c] <= (old+inc) mod 2^PHASE_W.
  - Output carries old (emitted phase precedes the add).
  - Counter increments and wraps N_CHAN-1 -> 0.
- Latency: fixed 2 ce-qualified cycles from advance to outputs. ce&!run injects a bubble (out_valid=0 two ce cycles later). ce=0 holds all pipeline registers and outputs unchanged.
- Read-modify-write: the same channel recurs only every N_CHAN>=2 advances, so no forwarding hazard beyond the 2-stage pipe. Implementation must still guarantee correct RMW for N_CHAN=2.
- Frame boundary = advance cycle with counter==N_CHAN-1. At its end:
  - if commit_pend: sel toggles, inc_ok=1, commit_pend=0
  - clr_frame <= clr_pend; clr_pend=0
  - Effects apply from channel 0 of the next frame.
- Config:
  - cfg_we writes shadow bank (!sel), independent of ce/run.
  - cfg_commit sets commit_pend. cfg_busy = commit_pend.
  - cfg_we or cfg_commit while busy: ignored.
  - After a swap the shadow holds the previous table; software rewrites all used channels before the next commit.
  - cfg_phase_clr sets clr_pend; repeated pulses are idempotent.
- Simultaneous events:
  - cfg_commit on a boundary cycle with busy=0: pend set, swap at the following boundary.
  - cfg_we and cfg_commit in the same cycle (busy=0): write lands, then commit.
  - cfg_phase_clr on a boundary cycle: applies at the next boundary.
- Reset mid-operation: outputs drop immediately; first frame after release emits phase 0 for all channels, with increments 0 until the first commit.

Test Plan:
- Reset, run=1 with N_CHAN=4, no commit -> out_valid rises 2 cycles after first advance; out_chan 0,1,2,3,0…; addr=frac=0 forever; out_first=1 on chan 0.
- Write ch1 inc=0x0040_0000, commit -> cfg_busy=1 until boundary; ch1 addr 0,1,2,… per frame; frac=0; other channels stay 0.
- ch2 inc=0x0000_0040 -> ch2 frac increments by 1 per frame, addr 0. inc=0xFFC0_0000 -> addr 0,1023,1022,… (wrap).
- Commit mid-frame (counter=1) -> channels 2,3 use old increments in the current frame; new table from chan 0 of the next frame; cfg_we during busy has no effect.
- cfg_phase_clr mid-frame -> next frame emits 0 for all channels; following frame emits exactly inc.
- ce toggled 0/1 randomly and run bubbles -> output sequence identical to the ce=1 reference, excluding bubbles. Assert reset mid-frame -> out_valid=0 immediately; after release, phases restart at 0.
